reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset controller that sits downstream of the board reset input and drives the per-domain active-low resets of the datapath (counter, registers, I/O), releasing them one at a time in a fixed order with a programmable gap. It contains its own asynchronous-assert/synchronous-deassert front end, so every output reset asserts immediately and deasserts only on a clock edge. A synchronous software reset request re-runs the full assert/release sequence without toggling `RESET`.

## Interface
- `NUM_STAGES`, default 4: number of reset domains driven. Range 1–8.
- `GAP_CYCLES`, default 16: CLOCK cycles between successive releases. Must be ≥1.
- `TIMEOUT_CYCLES`, default 64: acknowledge timeout. Used only with `RSTSEQ_ACK_EN`.
- `CLOCK` input, 1 bit: the single clock. All state changes on its rising edge.
- `RESET` input, 1 bit: reset, asynchronous, active-low.
- `SW_RST_REQ` input, 1 bit: synchronous software reset request, sampled high.
- `STAGE_ACK` input, `NUM_STAGES` bits: per-stage "domain out of reset" acknowledge. Present only with `RSTSEQ_ACK_EN`.
- `STAGE_RST_N` output, `NUM_STAGES` bits: active-low domain resets. Bit 0 is released first.
- `SEQ_DONE` output, 1 bit: all stages released.
- `BUSY` output, 1 bit: a sequence is in progress, or reset is held.
- `ERR` output, 1 bit: sticky acknowledge-timeout flag. Tied 0 without the macro.

## Operation
- Front end: a 2-flop synchronizer `rst_sync` with D tied to 1. Both flops clear asynchronously when `RESET`=0. `rst_sync` rises on the 2nd rising edge after `RESET` goes high.
- While `rst_sync`=0, all outputs are held at their reset values: `STAGE_RST_N`=0, `SEQ_DONE`=0, `BUSY`=1, `ERR`=0. The FSM is in HOLD and the counter is 0.
- FSM states: HOLD, RELEASE, DONE, ASSERT.
  - HOLD→RELEASE on the first edge with `rst_sync`=1. The counter starts at 0.
  - RELEASE: the counter increments each cycle. When it reaches `GAP_CYCLES`-1, on that edge:
    - deassert the next stage (`STAGE_RST_N[k]`←1),
    - clear the counter,
    - advance `k`.
  - After stage `NUM_STAGES`-1 is released, go to DONE on the next edge. On that edge `SEQ_DONE`←1 and `BUSY`←0.
  - DONE: hold. If `SW_RST_REQ`=1 at an edge, then on that edge:
    - `STAGE_RST_N`←0 (all bits at once),
    - `SEQ_DONE`←0, `BUSY`←1,
    - enter ASSERT with the counter at 0.
  - ASSERT: hold all stages asserted for `GAP_CYCLES` cycles, then enter RELEASE with the counter at 0 and `k`=0.
- `SW_RST_REQ` is ignored in HOLD, RELEASE and ASSERT. It is not queued.
- Released stages never re-assert except via `RESET` or the ASSERT state.
- `RESET` falling at any time, including mid-sequence or mid-ASSERT, asynchronously returns all flops to their reset values.
- Counter width is `$clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)+1)`. The counter never wraps: it is cleared at every release or timeout.

## Timing
- Edge 0 is the first rising edge after `RESET` rises. `rst_sync`=1 after edge 1.
- `STAGE_RST_N[k]` rises at edge 1+(k+1)·`GAP_CYCLES`.
- `SEQ_DONE` rises one edge after the last release.
- Software reset sampled at edge E:
  - outputs go low at E,
  - `STAGE_RST_N[k]` rises at E+(k+2)·`GAP_CYCLES`,
  - `SEQ_DONE` rises at E+(`NUM_STAGES`+1)·`GAP_CYCLES`+1.
- Assertion of any output by `RESET` is combinationally asynchronous. It does not wait for a clock edge.

## Configuration
- `RSTSEQ_ACK_EN` defined:
  - After releasing stage k, RELEASE waits for `STAGE_ACK[k]`=1 before counting the `GAP_CYCLES` gap to stage k+1.
  - The gap count starts on the edge where the acknowledge is sampled high.
  - If the acknowledge is not seen within `TIMEOUT_CYCLES` cycles of the release: set `ERR` (sticky), then proceed as if acknowledged.
  - `ERR` is cleared only by `RESET`; a software reset does not clear it.
- `RSTSEQ_ACK_EN` undefined: the `STAGE_ACK` port is absent, timing is purely gap-based, and `ERR`=0 constantly.

## Test plan
- Power-on, `NUM_STAGES`=4, `GAP_CYCLES`=16: release `RESET` → `STAGE_RST_N` steps 0000→0001→0011→0111→1111 at edges 17/33/49/65; `SEQ_DONE`=1 and `BUSY`=0 at edge 66.
- `SW_RST_REQ` pulse in DONE at edge E → `STAGE_RST_N`=0000 at E; bit 0 rises at E+32; `SEQ_DONE` at E+81. A second request sent while `BUSY`=1 is ignored.
- `RESET` pulled low mid-sequence (`STAGE_RST_N`=0011), between clock edges → all outputs return to reset values immediately; the sequence restarts from stage 0 after `RESET` rises.
- `RESET` deasserted with a glitch of less than 1 cycle → no output release before the full synchronizer plus gap delay.
- With `RSTSEQ_ACK_EN`, `TIMEOUT_CYCLES`=64, `STAGE_ACK[1]` held 0 → `ERR`=1 at 64 cycles after stage 1's release; stage 2 released 16 cycles later. `ERR` stays 1 through a software reset.
- With `RSTSEQ_ACK_EN`, each ack returned 3 cycles after its release → stage k+1 rises 3+16 edges after stage k; `ERR` stays 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset controller. A 2-flop async-assert / sync-deassert front end
//   conditions the board reset. A single FSM then releases the per-domain
//   active-low resets one at a time, in bit order, with a programmable gap
//   between releases. A software request in DONE re-runs the whole
//   assert/release sequence without touching RESET.
//
//   Optional feature, selected by the macro RSTSEQ_ACK_EN:
//     After each release except the last, the FSM waits for that domain's
//     acknowledge before it counts the gap to the next release. If no
//     acknowledge arrives within TIMEOUT_CYCLES, the sticky ERR flag is set
//     and the sequence continues. Without the macro the STAGE_ACK port is
//     absent and ERR is tied low.
//
// Parameters
//   NUM_STAGES     : number of reset domains (1..8)
//   GAP_CYCLES     : clock cycles between successive releases (>= 1)
//   TIMEOUT_CYCLES : acknowledge timeout (used only with RSTSEQ_ACK_EN)
//
// Ports
//   CLOCK       : single clock; all state changes on its rising edge
//   RESET       : asynchronous active-low reset
//   SW_RST_REQ  : synchronous software reset request; honoured only in DONE
//   STAGE_ACK   : per-domain "out of reset" acknowledge (RSTSEQ_ACK_EN only)
//   STAGE_RST_N : active-low domain resets; bit 0 is released first
//   SEQ_DONE    : all domains released
//   BUSY        : a sequence is in progress, or reset is held
//   ERR         : sticky acknowledge-timeout flag
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  SW_RST_REQ,
`ifdef RSTSEQ_ACK_EN
  input  logic [NUM_STAGES-1:0] STAGE_ACK,
`endif
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  SEQ_DONE,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int KW      = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [KW-1:0] K_END    = KW'(NUM_STAGES);
`ifdef RSTSEQ_ACK_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_STAGES - 1);
`endif

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ASSERT  = 2'd3
  } state_t;

  // Front end: reset synchronizer, D tied high
  logic sync_q1;
  logic rst_sync;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync_q1  <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      sync_q1  <= 1'b1;
      rst_sync <= sync_q1;
    end
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;      // index of the next stage to release

`ifdef RSTSEQ_ACK_EN
  logic wait_ack;
  logic err_q;
  logic ack_cur;

  // Acknowledge of the most recently released stage (k-1)
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (k == KW'(i + 1)) ack_cur = STAGE_ACK[i];
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      k           <= '0;
      STAGE_RST_N <= '0;
      SEQ_DONE    <= 1'b0;
      BUSY        <= 1'b1;
`ifdef RSTSEQ_ACK_EN
      wait_ack    <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        // The HOLD exit edge already counts as the first gap cycle
        // (counter value 0), so HOLD and RELEASE share the release step.
        // The FSM can only sit outside HOLD while rst_sync is high.
        ST_HOLD, ST_RELEASE: begin
          if (rst_sync) begin
            state <= ST_RELEASE;
            if (k == K_END) begin
              state    <= ST_DONE;
              SEQ_DONE <= 1'b1;
              BUSY     <= 1'b0;
            end
`ifdef RSTSEQ_ACK_EN
            else if (wait_ack) begin
              // The gap count restarts on the edge that sees the ack,
              // or on the timeout edge, which otherwise behaves alike.
              if (ack_cur) begin
                wait_ack <= 1'b0;
                cnt      <= '0;
              end else if (cnt == TMO_LAST) begin
                wait_ack <= 1'b0;
                cnt      <= '0;
                err_q    <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
`endif
            else if (cnt == GAP_LAST) begin
              for (int i = 0; i < NUM_STAGES; i++) begin
                if (k == KW'(i)) STAGE_RST_N[i] <= 1'b1;
              end
              cnt <= '0;
              k   <= k + 1'b1;
`ifdef RSTSEQ_ACK_EN
              // The last stage does not gate anything, so no wait after it
              wait_ack <= (k != K_LAST);
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (SW_RST_REQ) begin
            STAGE_RST_N <= '0;
            SEQ_DONE    <= 1'b0;
            BUSY        <= 1'b1;
            cnt         <= '0;
            state       <= ST_ASSERT;
          end
        end

        ST_ASSERT: begin
          if (cnt == GAP_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            k     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer (NUM_STAGES=4, GAP_CYCLES=16,
//   TIMEOUT_CYCLES=64). Expected values are hand-computed edge checkpoints
//   counted from the first rising edge after RESET rises (edge 0), or from
//   the edge that samples a software request.
module tb_reset_sequencer;

  localparam int NS = 4;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          SW_RST_REQ = 1'b0;
  logic [NS-1:0] STAGE_RST_N;
  logic          SEQ_DONE;
  logic          BUSY;
  logic          ERR;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

`ifdef RSTSEQ_ACK_EN
  // Acknowledge model: each domain answers so that its ack is sampled high
  // on the 3rd edge after its release, unless blocked.
  logic [NS-1:0] STAGE_ACK;
  logic [NS-1:0] d1 = '0;
  logic [NS-1:0] d2 = '0;
  logic [NS-1:0] ack_block = '0;

  always @(posedge CLOCK) begin
    d1 <= STAGE_RST_N;
    d2 <= d1;
  end

  assign STAGE_ACK = d2 & ~ack_block;
`endif

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .GAP_CYCLES    (16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .SW_RST_REQ (SW_RST_REQ),
`ifdef RSTSEQ_ACK_EN
    .STAGE_ACK  (STAGE_ACK),
`endif
    .STAGE_RST_N(STAGE_RST_N),
    .SEQ_DONE   (SEQ_DONE),
    .BUSY       (BUSY),
    .ERR        (ERR)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int         e;
    logic [3:0] st;
    logic       d;
    logic       b;
    logic       er;
  } cp_t;

  cp_t tbl[12];
  int  tbl_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] st, input logic d,
                            input logic b, input logic er);
    chk({tag, "_rst_n"}, 32'(STAGE_RST_N), 32'(st));
    chk({tag, "_done"},  32'(SEQ_DONE),    32'(d));
    chk({tag, "_busy"},  32'(BUSY),        32'(b));
    chk({tag, "_err"},   32'(ERR),         32'(er));
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
    ecnt++;
  endtask

  // Release RESET between edges; the next rising edge becomes edge 0
  task automatic release_rst();
    @(negedge CLOCK);
    RESET = 1'b1;
    ecnt  = -1;
  endtask

  // Software request sampled on the next edge; ecnt then names that edge
  task automatic pulse_sw();
    @(negedge CLOCK);
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
  endtask

  task automatic set_cp(input int i, input int e, input logic [3:0] st, input logic d,
                        input logic b, input logic er);
    tbl[i].e  = e;
    tbl[i].st = st;
    tbl[i].d  = d;
    tbl[i].b  = b;
    tbl[i].er = er;
    tbl_n     = i + 1;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl_n; i++) begin
      while (ecnt < tbl[i].e) tick();
      check_outs($sformatf("%s_e%0d", tag, tbl[i].e), tbl[i].st, tbl[i].d, tbl[i].b, tbl[i].er);
    end
  endtask

  task automatic load_power_on();
    set_cp(0, 1,  4'b0000, 1'b0, 1'b1, 1'b0);
    set_cp(1, 16, 4'b0000, 1'b0, 1'b1, 1'b0);
    set_cp(2, 17, 4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(3, 32, 4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(4, 33, 4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(5, 48, 4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(6, 49, 4'b0111, 1'b0, 1'b1, 1'b0);
    set_cp(7, 64, 4'b0111, 1'b0, 1'b1, 1'b0);
    set_cp(8, 65, 4'b1111, 1'b0, 1'b1, 1'b0);
    set_cp(9, 66, 4'b1111, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held
    repeat (3) tick();
    check_outs("por_hold", 4'b0000, 1'b0, 1'b1, 1'b0);

`ifndef RSTSEQ_ACK_EN
    // Power-on release sequence
    release_rst();
    load_power_on();
    run_tbl("pwr");

    // Software reset from DONE, with two requests that must be ignored
    repeat (5) tick();
    check_outs("done_idle", 4'b1111, 1'b1, 1'b0, 1'b0);
    pulse_sw();
    ecnt = 0;
    check_outs("sw_e0", 4'b0000, 1'b0, 1'b1, 1'b0);
    while (ecnt < 4) tick();
    pulse_sw();                       // edge 5: in ASSERT
    set_cp(0, 31, 4'b0000, 1'b0, 1'b1, 1'b0);
    set_cp(1, 32, 4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(2, 39, 4'b0001, 1'b0, 1'b1, 1'b0);
    run_tbl("sw");
    pulse_sw();                       // edge 40: in RELEASE
    set_cp(0, 47, 4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(1, 48, 4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(2, 63, 4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(3, 64, 4'b0111, 1'b0, 1'b1, 1'b0);
    set_cp(4, 80, 4'b1111, 1'b0, 1'b1, 1'b0);
    set_cp(5, 81, 4'b1111, 1'b1, 1'b0, 1'b0);
    set_cp(6, 90, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_tbl("sw");

    // RESET asserted between edges acts without a clock edge
    @(negedge CLOCK);
    #2 RESET = 1'b0;
    #1 check_outs("async_done", 4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    release_rst();
    while (ecnt < 40) tick();
    check_outs("mid_e40", 4'b0011, 1'b0, 1'b1, 1'b0);
    #3 RESET = 1'b0;
    #1 check_outs("async_mid", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("mid_held", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Sub-cycle RESET glitch spanning a rising edge must not release anything
    @(posedge CLOCK);
    #8 RESET = 1'b1;
    #4 RESET = 1'b0;
    #1 check_outs("glitch", 4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check_outs("glitch_held", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Full restart from stage 0
    release_rst();
    load_power_on();
    run_tbl("restart");
`else
    // Acks returned 3 edges after each release
    release_rst();
    set_cp(0, 17, 4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(1, 35, 4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(2, 36, 4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(3, 54, 4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(4, 55, 4'b0111, 1'b0, 1'b1, 1'b0);
    set_cp(5, 73, 4'b0111, 1'b0, 1'b1, 1'b0);
    set_cp(6, 74, 4'b1111, 1'b0, 1'b1, 1'b0);
    set_cp(7, 75, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_tbl("ack3");

    // Stage 1 never acknowledges: timeout 64 after its release
    @(negedge CLOCK);
    RESET     = 1'b0;
    ack_block = 4'b0010;
    repeat (4) tick();
    release_rst();
    set_cp(0, 17,  4'b0001, 1'b0, 1'b1, 1'b0);
    set_cp(1, 36,  4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(2, 99,  4'b0011, 1'b0, 1'b1, 1'b0);
    set_cp(3, 100, 4'b0011, 1'b0, 1'b1, 1'b1);
    set_cp(4, 115, 4'b0011, 1'b0, 1'b1, 1'b1);
    set_cp(5, 116, 4'b0111, 1'b0, 1'b1, 1'b1);
    set_cp(6, 134, 4'b0111, 1'b0, 1'b1, 1'b1);
    set_cp(7, 135, 4'b1111, 1'b0, 1'b1, 1'b1);
    set_cp(8, 136, 4'b1111, 1'b1, 1'b0, 1'b1);
    run_tbl("tmo");

    // ERR survives a software reset, cleared only by RESET
    repeat (3) tick();
    pulse_sw();
    ecnt = 0;
    check_outs("tmo_sw_e0", 4'b0000, 1'b0, 1'b1, 1'b1);
    set_cp(0, 31, 4'b0000, 1'b0, 1'b1, 1'b1);
    set_cp(1, 32, 4'b0001, 1'b0, 1'b1, 1'b1);
    run_tbl("tmo_sw");
    @(negedge CLOCK);
    RESET = 1'b0;
    #1 check_outs("err_clr", 4'b0000, 1'b0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
